// File: rtl/countdown_pkg.sv
// Shared types and constants for the MM:SS countdown controller.
package countdown_pkg;

    localparam int unsigned DIGIT_W = 4;
    localparam logic [DIGIT_W-1:0] MAX_TENS = 4'd5;
    localparam logic [DIGIT_W-1:0] MAX_ONES = 4'd9;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_PAUSE,
        ST_ALARM,
        ST_CLR
    } state_t;

    // Range check only; the non-zero requirement is applied by the caller.
    function automatic logic preset_valid(
        input logic [DIGIT_W-1:0] mt,
        input logic [DIGIT_W-1:0] mo,
        input logic [DIGIT_W-1:0] st,
        input logic [DIGIT_W-1:0] so
    );
        return (mt <= MAX_TENS) && (mo <= MAX_ONES) &&
               (st <= MAX_TENS) && (so <= MAX_ONES);
    endfunction

endpackage

// File: rtl/countdown_ctrl_tick_gen.sv
// Count-tick prescaler: counts while running, freezes on hold, zeroes otherwise.
module tick_gen #(
    parameter int unsigned TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic hold,
    input  logic clr,
    output logic tick
);

    localparam int unsigned W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [W-1:0] cnt;

    assign tick = (cnt == W'(TICK_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (hold) begin
            cnt <= cnt;
        end else if (run) begin
            cnt <= tick ? '0 : cnt + 1'b1;
        end else begin
            cnt <= '0;
        end
    end

endmodule

// File: rtl/countdown_ctrl.sv
// Control FSM for the MM:SS countdown: sequences the seconds/minutes BCD
// counters, detects 00:00 and drives the alarm.
module countdown_ctrl
    import countdown_pkg::*;
#(
    parameter int unsigned TICK_DIV    = 50_000_000,
    parameter int unsigned ALARM_TICKS = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_stop,
    input  logic               clear,
    input  logic [DIGIT_W-1:0] set_mt,
    input  logic [DIGIT_W-1:0] set_mo,
    input  logic [DIGIT_W-1:0] set_st,
    input  logic [DIGIT_W-1:0] set_so,
    input  logic [DIGIT_W-1:0] min_t,
    input  logic [DIGIT_W-1:0] min_o,
    input  logic [DIGIT_W-1:0] sec_t,
    input  logic [DIGIT_W-1:0] sec_o,
    output logic               cnt_load,
    output logic               cnt_clr,
    output logic               sec_en,
    output logic               min_en,
    output logic               running,
    output logic               paused,
    output logic               alarm,
    output logic               set_err
);

    localparam int unsigned AW = $clog2(ALARM_TICKS + 1);

    state_t        state, nxt;
    logic [AW-1:0] acnt;
    logic          tick;
    logic          sec_zero, all_zero, start_ok;
    logic          pre_run, pre_hold, pre_clr;

    assign sec_zero = (sec_t == '0) && (sec_o == '0);
    assign all_zero = sec_zero && (min_t == '0) && (min_o == '0);
    assign start_ok = preset_valid(set_mt, set_mo, set_st, set_so) &&
                      (|{set_mt, set_mo, set_st, set_so});

    // Clearing on the RUN->ALARM cycle makes the alarm period start from 0.
    assign pre_run  = (state == ST_RUN) || (state == ST_ALARM);
    assign pre_hold = (state == ST_PAUSE);
    assign pre_clr  = !(pre_run || pre_hold) || ((state == ST_RUN) && all_zero);

    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .run  (pre_run),
        .hold (pre_hold),
        .clr  (pre_clr),
        .tick (tick)
    );

    assign sec_en = (state == ST_RUN) && tick && !all_zero;
    assign min_en = sec_en && sec_zero;

    always_comb begin
        nxt = state;
        unique case (state)
            ST_IDLE:  if (clear) nxt = ST_CLR;
                      else if (start_stop && start_ok) nxt = ST_LOAD;
            ST_LOAD:  nxt = clear ? ST_CLR : ST_RUN;
            ST_RUN:   if (clear) nxt = ST_CLR;
                      else if (all_zero) nxt = ST_ALARM;
                      else if (start_stop) nxt = ST_PAUSE;
            ST_PAUSE: if (clear) nxt = ST_CLR;
                      else if (start_stop) nxt = ST_RUN;
            ST_ALARM: if (clear) nxt = ST_CLR;
                      else if (start_stop || (tick && acnt == AW'(ALARM_TICKS - 1)))
                          nxt = ST_IDLE;
            ST_CLR:   nxt = ST_IDLE;
            default:  nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            acnt     <= '0;
            cnt_load <= 1'b0;
            cnt_clr  <= 1'b0;
            running  <= 1'b0;
            paused   <= 1'b0;
            alarm    <= 1'b0;
            set_err  <= 1'b0;
        end else begin
            state    <= nxt;
            acnt     <= (state == ST_ALARM && nxt == ST_ALARM && tick) ? acnt + 1'b1 :
                        (state == ST_ALARM && nxt == ST_ALARM)         ? acnt : '0;
            cnt_load <= (nxt == ST_LOAD);
            cnt_clr  <= (nxt == ST_CLR);
            running  <= (nxt == ST_RUN);
            paused   <= (nxt == ST_PAUSE);
            alarm    <= (nxt == ST_ALARM);
            set_err  <= (state == ST_IDLE) && start_stop && !clear && !start_ok;
        end
    end

endmodule

// File: tb/tb_countdown_ctrl.sv
// Directed bench for countdown_ctrl with behavioural models of the two
// bcd_down_00_59 counters closing the loop.
module tb_countdown_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_stop = 1'b0;
    logic       clear = 1'b0;
    logic [3:0] set_mt = '0, set_mo = '0, set_st = '0, set_so = '0;
    logic [3:0] min_t = '0, min_o = '0, sec_t = '0, sec_o = '0;
    logic       cnt_load, cnt_clr, sec_en, min_en, running, paused, alarm, set_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    countdown_ctrl #(.TICK_DIV(4), .ALARM_TICKS(3)) dut (
        .clk(clk), .rst(rst), .start_stop(start_stop), .clear(clear),
        .set_mt(set_mt), .set_mo(set_mo), .set_st(set_st), .set_so(set_so),
        .min_t(min_t), .min_o(min_o), .sec_t(sec_t), .sec_o(sec_o),
        .cnt_load(cnt_load), .cnt_clr(cnt_clr), .sec_en(sec_en), .min_en(min_en),
        .running(running), .paused(paused), .alarm(alarm), .set_err(set_err)
    );

    // Seconds and minutes bcd_down_00_59 counters.
    always @(posedge clk) begin
        if (cnt_clr) begin
            {min_t, min_o, sec_t, sec_o} <= '0;
        end else if (cnt_load) begin
            {min_t, min_o, sec_t, sec_o} <= {set_mt, set_mo, set_st, set_so};
        end else begin
            if (sec_en) begin
                if (sec_o != 0) sec_o <= sec_o - 1;
                else begin sec_o <= 4'd9; sec_t <= (sec_t == 0) ? 4'd5 : sec_t - 1; end
            end
            if (min_en) begin
                if (min_o != 0) min_o <= min_o - 1;
                else begin min_o <= 4'd9; min_t <= (min_t == 0) ? 4'd5 : min_t - 1; end
            end
        end
    end

    function automatic logic [7:0] outs();
        return {cnt_load, cnt_clr, sec_en, min_en, running, paused, alarm, set_err};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic pulse_ss();
        start_stop = 1'b1; cyc(1); start_stop = 1'b0;
    endtask

    task automatic preset(input logic [15:0] v);
        {set_mt, set_mo, set_st, set_so} = v;
    endtask

    task automatic do_clear();
        clear = 1'b1; cyc(1); clear = 1'b0; cyc(1);
    endtask

    // Output vector order: load clr sec_en min_en running paused alarm set_err
    initial begin
        int n;
        cyc(3);
        check("reset_outs", 32'(outs()), 32'h00);
        rst = 1'b0;
        cyc(1);
        check("idle_outs", 32'(outs()), 32'h00);

        // 01:05 start, first tick, and the 01:00 -> 00:59 borrow
        preset(16'h0105);
        pulse_ss();
        check("load_pulse", 32'(outs()), 32'h80);
        cyc(1);
        check("run_entry", 32'(outs()), 32'h08);
        check("loaded_digits", 32'({min_t, min_o, sec_t, sec_o}), 32'h0105);
        cyc(2);
        check("no_en_early", 32'(sec_en), 32'h0);
        cyc(1);
        check("first_sec_en", 32'(outs()), 32'h28);
        cyc(1);
        check("digits_0104", 32'({min_t, min_o, sec_t, sec_o}), 32'h0104);
        cyc(19);
        check("borrow_tick", 32'(outs()), 32'h38);
        cyc(1);
        check("digits_0059", 32'({min_t, min_o, sec_t, sec_o}), 32'h0059);

        // clear wins over a simultaneous start_stop in RUN
        clear = 1'b1; start_stop = 1'b1; cyc(1); clear = 1'b0; start_stop = 1'b0;
        check("clr_state", 32'(outs()), 32'h40);
        cyc(1);
        check("clr_idle", 32'(outs()), 32'h00);
        check("clr_digits", 32'({min_t, min_o, sec_t, sec_o}), 32'h0000);

        // 00:02 runs out; alarm for 12 clocks then auto-return to IDLE
        preset(16'h0002);
        pulse_ss();
        cyc(9);
        check("zero_reached", 32'({min_t, min_o, sec_t, sec_o}), 32'h0000);
        check("zero_still_run", 32'(outs()), 32'h08);
        cyc(1);
        check("alarm_entry", 32'(outs()), 32'h02);
        n = 0;
        for (int i = 0; i < 13; i++) begin
            cyc(1);
            if (alarm) n++;
            if (sec_en || min_en) n += 100;
        end
        check("alarm_len", 32'(n), 32'd11);
        check("alarm_done", 32'(outs()), 32'h00);
        check("alarm_digits", 32'({min_t, min_o, sec_t, sec_o}), 32'h0000);

        // start_stop acknowledges the alarm early
        preset(16'h0001);
        pulse_ss();
        cyc(6);
        check("ack_alarm_on", 32'(alarm), 32'h1);
        pulse_ss();
        check("ack_idle", 32'(outs()), 32'h00);

        // pause with prescaler at 2, hold, resume
        preset(16'h0030);
        pulse_ss();
        cyc(2);
        pulse_ss();
        check("paused", 32'(outs()), 32'h04);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(1);
            if (sec_en || min_en) n++;
        end
        check("pause_no_en", 32'(n), 32'd0);
        check("pause_digits", 32'({min_t, min_o, sec_t, sec_o}), 32'h0030);
        pulse_ss();
        check("resume_run", 32'(outs()), 32'h08);
        cyc(1);
        check("resume_sec_en", 32'(outs()), 32'h28);
        cyc(1);
        check("resume_digits", 32'({min_t, min_o, sec_t, sec_o}), 32'h0029);
        do_clear();

        // refused starts in IDLE
        preset(16'h0000);
        pulse_ss();
        check("err_zero", 32'(outs()), 32'h01);
        cyc(1);
        check("err_pulse_end", 32'(outs()), 32'h00);
        preset(16'h0160);
        pulse_ss();
        check("err_range", 32'(outs()), 32'h01);
        cyc(1);
        check("err_range_end", 32'(outs()), 32'h00);
        clear = 1'b1; start_stop = 1'b1; cyc(1); clear = 1'b0; start_stop = 1'b0;
        check("clr_no_err", 32'(outs()), 32'h40);
        cyc(1);

        // rst mid-RUN on the edge that would raise sec_en
        preset(16'h0105);
        pulse_ss();
        cyc(3);
        rst = 1'b1;
        cyc(1);
        check("rst_mid_run", 32'(outs()), 32'h00);
        rst = 1'b0;
        cyc(4);
        check("rst_stays_idle", 32'(outs()), 32'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
